// File: rtl/cnt_event_sampler.sv
// cnt_event_sampler: samples a 4-bit counter, classifies each qualified
// transition (wrap / jump / restart) and queues non-normal transitions in a
// show-ahead FIFO drained over a valid/ready port. Saturating wrap and drop
// statistics are kept alongside.
// Optional feature macro: CNT_EVENT_SAMPLER_TIMESTAMP_EN prepends a 16-bit
// cycle timestamp to every record (evt_data widens from 10 to 26 bits).
module cnt_event_sampler #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned STAT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        cnt_in,
   input  logic              cnt_valid,
   output logic              evt_valid,
   input  logic              evt_ready,
`ifdef CNT_EVENT_SAMPLER_TIMESTAMP_EN
   output logic [25:0]       evt_data,
`else
   output logic [9:0]        evt_data,
`endif
   output logic              fifo_full,
   output logic              overflow,
   output logic [STAT_W-1:0] wrap_count,
   output logic [STAT_W-1:0] drop_count
);

`ifdef CNT_EVENT_SAMPLER_TIMESTAMP_EN
   localparam int unsigned REC_W = 26;
`else
   localparam int unsigned REC_W = 10;
`endif
   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

   typedef enum logic [0:0] {ST_INIT, ST_TRACK} state_t;
   typedef enum logic [1:0] {
      EV_NONE    = 2'b00,
      EV_WRAP    = 2'b01,
      EV_JUMP    = 2'b10,
      EV_RESTART = 2'b11
   } evt_t;

   state_t             state_q, state_d;
   logic [3:0]         prev_q, prev_d;
   logic [AW:0]        wr_ptr_q, wr_ptr_d;
   logic [AW:0]        rd_ptr_q, rd_ptr_d;
   logic [REC_W-1:0]   head_q, head_d;
   logic               valid_q, valid_d;
   logic               full_q, full_d;
   logic               ovf_q, ovf_d;
   logic [STAT_W-1:0]  wrap_q, wrap_d;
   logic [STAT_W-1:0]  drop_q, drop_d;
   logic [REC_W-1:0]   mem_q [DEPTH];
`ifdef CNT_EVENT_SAMPLER_TIMESTAMP_EN
   logic [15:0]        ts_q, ts_d;
`endif

   evt_t               evt_type;
   logic [3:0]         prev_inc;
   logic [REC_W-1:0]   rec;
   logic [AW:0]        occupancy;
   logic               full_now;
   logic               push;
   logic               pop;
   logic               push_acc;
   logic               drop;

   // State register for the INIT/TRACK tracker
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: the first qualified sample moves INIT to TRACK, TRACK holds
   always_comb begin
      state_d = state_q;
      if (cnt_valid) begin
         state_d = ST_TRACK;
      end
   end

   // Classification of the current sample against the previous one
   always_comb begin
      evt_type = EV_NONE;
      prev_inc = prev_q + 4'd1;
      prev_d   = prev_q;
      if (cnt_valid) begin
         prev_d = cnt_in;
         if (state_q == ST_TRACK) begin
            if (cnt_in == prev_q) begin
               evt_type = EV_NONE;
            end else if (prev_q == 4'hF && cnt_in == 4'h0) begin
               evt_type = EV_WRAP;
            end else if (cnt_in == 4'h0) begin
               evt_type = EV_RESTART;
            end else if (cnt_in == prev_inc) begin
               evt_type = EV_NONE;
            end else begin
               evt_type = EV_JUMP;
            end
         end
      end
   end

   // FIFO control, registered head lookahead and statistics next values
   always_comb begin
`ifdef CNT_EVENT_SAMPLER_TIMESTAMP_EN
      rec  = {ts_q, evt_type, prev_q, cnt_in};
      ts_d = ts_q + 16'd1;
`else
      rec  = {evt_type, prev_q, cnt_in};
`endif
      occupancy = wr_ptr_q - rd_ptr_q;
      full_now  = (occupancy == FULL_OCC);
      pop       = valid_q && evt_ready;
      push      = (evt_type != EV_NONE);
      push_acc  = push && (!full_now || pop);
      drop      = push && full_now && !pop;

      wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push_acc};
      rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};

      // The head register is preloaded with whatever sits at the new read
      // pointer; when that slot is being written this same edge (empty FIFO
      // or pop catching up with the push), the incoming record bypasses mem.
      if (wr_ptr_d == rd_ptr_d) begin
         head_d = '0;
      end else if (push_acc && (rd_ptr_d == wr_ptr_q)) begin
         head_d = rec;
      end else begin
         head_d = mem_q[rd_ptr_d[AW-1:0]];
      end

      valid_d = (wr_ptr_d != rd_ptr_d);
      full_d  = ((wr_ptr_d - rd_ptr_d) == FULL_OCC);
      ovf_d   = ovf_q | drop;

      wrap_d = wrap_q;
      if (evt_type == EV_WRAP && wrap_q != '1) begin
         wrap_d = wrap_q + STAT_W'(1);
      end
      drop_d = drop_q;
      if (drop && drop_q != '1) begin
         drop_d = drop_q + STAT_W'(1);
      end
   end

   // Datapath and statistics registers
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
         wrap_q   <= '0;
         drop_q   <= '0;
`ifdef CNT_EVENT_SAMPLER_TIMESTAMP_EN
         ts_q     <= '0;
`endif
      end else begin
         prev_q   <= prev_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         head_q   <= head_d;
         valid_q  <= valid_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
         wrap_q   <= wrap_d;
         drop_q   <= drop_d;
`ifdef CNT_EVENT_SAMPLER_TIMESTAMP_EN
         ts_q     <= ts_d;
`endif
      end
   end

   // Record storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (!rst && push_acc) begin
         mem_q[wr_ptr_q[AW-1:0]] <= rec;
      end
   end

   assign evt_valid  = valid_q;
   assign evt_data   = head_q;
   assign fifo_full  = full_q;
   assign overflow   = ovf_q;
   assign wrap_count = wrap_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_cnt_event_sampler.sv
// Self-checking bench for cnt_event_sampler: queue-based reference model
// compared every cycle, plus directed literal checks.
// Optional feature macro: CNT_EVENT_SAMPLER_TIMESTAMP_EN.
module tb_cnt_event_sampler;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned STAT_W = 3;
   localparam int          SATMAX = (1 << STAT_W) - 1;
`ifdef CNT_EVENT_SAMPLER_TIMESTAMP_EN
   localparam int unsigned REC_W = 26;
`else
   localparam int unsigned REC_W = 10;
`endif

   logic              clk;
   logic              rst;
   logic [3:0]        cnt_in;
   logic              cnt_valid;
   logic              evt_valid;
   logic              evt_ready;
   logic [REC_W-1:0]  evt_data;
   logic              fifo_full;
   logic              overflow;
   logic [STAT_W-1:0] wrap_count;
   logic [STAT_W-1:0] drop_count;

   cnt_event_sampler #(.DEPTH(DEPTH), .STAT_W(STAT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cnt_in     (cnt_in),
      .cnt_valid  (cnt_valid),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_data   (evt_data),
      .fifo_full  (fifo_full),
      .overflow   (overflow),
      .wrap_count (wrap_count),
      .drop_count (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: records as a queue, transitions classified arithmetically
   logic [REC_W-1:0] mq[$];
   int  m_prev, m_wrap, m_drop, m_ts, m_typ, m_sz, m_diff;
   bit  m_track, m_ovf, m_pop;
   logic [REC_W-1:0] m_rec;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_prev = 0; m_track = 0; m_wrap = 0; m_drop = 0; m_ovf = 0; m_ts = 0;
      end else begin
         m_sz  = mq.size();
         m_pop = (m_sz > 0) && evt_ready;
         m_typ = 0;
         if (cnt_valid) begin
            if (m_track) begin
               m_diff = (int'(cnt_in) - m_prev + 16) % 16;
               if (m_diff == 0)       m_typ = 0;
               else if (cnt_in == 0)  m_typ = (m_prev == 15) ? 1 : 3;
               else if (m_diff == 1)  m_typ = 0;
               else                   m_typ = 2;
            end
`ifdef CNT_EVENT_SAMPLER_TIMESTAMP_EN
            m_rec = REC_W'((m_ts << 10) | (m_typ << 8) | (m_prev << 4) | int'(cnt_in));
`else
            m_rec = REC_W'((m_typ << 8) | (m_prev << 4) | int'(cnt_in));
`endif
            m_track = 1;
            m_prev  = int'(cnt_in);
         end
         if (m_pop) void'(mq.pop_front());
         if (m_typ != 0) begin
            if (m_sz < int'(DEPTH) || m_pop) mq.push_back(m_rec);
            else begin
               m_ovf = 1;
               if (m_drop < SATMAX) m_drop++;
            end
         end
         if (m_typ == 1 && m_wrap < SATMAX) m_wrap++;
         m_ts = (m_ts + 1) % 65536;
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("evt_valid", 32'(evt_valid), 32'(mq.size() != 0));
         check("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
         check("overflow", 32'(overflow), 32'(m_ovf));
         check("wrap_count", 32'(wrap_count), 32'(m_wrap));
         check("drop_count", 32'(drop_count), 32'(m_drop));
         if (mq.size() != 0) check("evt_data", 32'(evt_data), 32'(mq[0]));
      end
   end

   task automatic cyc(input logic [3:0] c, input logic v, input logic r);
      cnt_in = c; cnt_valid = v; evt_ready = r;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; cnt_valid = 1'b0; evt_ready = 1'b0; cnt_in = 4'd0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
   endtask

   initial begin
      rst = 1'b1; cnt_in = 4'd0; cnt_valid = 1'b0; evt_ready = 1'b0;

      // Reset state
      do_reset();
      check("rst_valid", 32'(evt_valid), 32'd0);
      check("rst_data", 32'(evt_data), 32'd0);
      check("rst_wrap", 32'(wrap_count), 32'd0);

      // Free count 1..15,0,1: single WRAP record
      cyc(4'd1, 1'b1, 1'b1);
      for (int i = 2; i <= 15; i++) cyc(4'(i), 1'b1, 1'b1);
      check("t1_no_evt_before_wrap", 32'(evt_valid), 32'd0);
      cyc(4'd0, 1'b1, 1'b1);
      check("t1_wrap_valid", 32'(evt_valid), 32'd1);
      check("t1_wrap_data", 32'(evt_data[9:0]), 32'h1F0);
      check("t1_wrap_count", 32'(wrap_count), 32'd1);
      cyc(4'd1, 1'b1, 1'b1);
      check("t1_valid_drop", 32'(evt_valid), 32'd0);

      // Jump then restart
      do_reset();
      cyc(4'd3, 1'b1, 1'b0);
      cyc(4'd4, 1'b1, 1'b0);
      cyc(4'd9, 1'b1, 1'b0);
      check("t2_jump_data", 32'(evt_data[9:0]), 32'h249);
      cyc(4'd0, 1'b1, 1'b1);
      check("t2_restart_data", 32'(evt_data[9:0]), 32'h390);
      check("t2_wrap_count", 32'(wrap_count), 32'd0);
      cyc(4'd0, 1'b1, 1'b1);
      check("t2_empty", 32'(evt_valid), 32'd0);

      // Stall and cnt_valid gating
      do_reset();
      for (int i = 0; i < 5; i++) cyc(4'd7, 1'b1, 1'b1);
      check("t3_stall", 32'(evt_valid), 32'd0);
      cyc(4'd8, 1'b1, 1'b1);
      cyc(4'd2, 1'b0, 1'b1);
      cyc(4'd8, 1'b0, 1'b1);
      cyc(4'd9, 1'b1, 1'b1);
      check("t3_gated", 32'(evt_valid), 32'd0);

      // Overflow: 6 jumps into a 4-deep FIFO, then drain
      do_reset();
      cyc(4'd0, 1'b1, 1'b0);
      cyc(4'd5, 1'b1, 1'b0);
      cyc(4'd10, 1'b1, 1'b0);
      cyc(4'd3, 1'b1, 1'b0);
      check("t4_not_full", 32'(fifo_full), 32'd0);
      cyc(4'd8, 1'b1, 1'b0);
      check("t4_full", 32'(fifo_full), 32'd1);
      cyc(4'd13, 1'b1, 1'b0);
      cyc(4'd2, 1'b1, 1'b0);
      check("t4_drop_count", 32'(drop_count), 32'd2);
      check("t4_overflow", 32'(overflow), 32'd1);
      check("t4_head0", 32'(evt_data[9:0]), 32'h205);
      cyc(4'd2, 1'b1, 1'b1);
      check("t4_head1", 32'(evt_data[9:0]), 32'h25A);
      cyc(4'd2, 1'b1, 1'b1);
      check("t4_head2", 32'(evt_data[9:0]), 32'h2A3);
      cyc(4'd2, 1'b1, 1'b1);
      check("t4_head3", 32'(evt_data[9:0]), 32'h238);
      cyc(4'd2, 1'b1, 1'b1);
      check("t4_drained", 32'(evt_valid), 32'd0);
      check("t4_ovf_sticky", 32'(overflow), 32'd1);

      // Full FIFO with simultaneous push and pop
      do_reset();
      cyc(4'd0, 1'b1, 1'b0);
      cyc(4'd5, 1'b1, 1'b0);
      cyc(4'd10, 1'b1, 1'b0);
      cyc(4'd3, 1'b1, 1'b0);
      cyc(4'd8, 1'b1, 1'b0);
      cyc(4'd13, 1'b1, 1'b1);
      check("t5_no_drop", 32'(drop_count), 32'd0);
      check("t5_still_full", 32'(fifo_full), 32'd1);
      check("t5_head", 32'(evt_data[9:0]), 32'h25A);
      cyc(4'd13, 1'b1, 1'b1);
      cyc(4'd13, 1'b1, 1'b1);
      cyc(4'd13, 1'b1, 1'b1);
      check("t5_last", 32'(evt_data[9:0]), 32'h28D);
      cyc(4'd13, 1'b1, 1'b1);
      check("t5_empty", 32'(evt_valid), 32'd0);

      // Saturation of wrap_count and drop_count
      do_reset();
      for (int k = 0; k <= 16 * 9; k++) cyc(4'(k % 16), 1'b1, 1'b1);
      check("t6_wrap_sat", 32'(wrap_count), 32'(SATMAX));
      do_reset();
      for (int k = 0; k < 15; k++) cyc(4'((k * 5) % 16), 1'b1, 1'b0);
      check("t6_drop_sat", 32'(drop_count), 32'(SATMAX));

      // Reset with records queued
      do_reset();
      cyc(4'd0, 1'b1, 1'b0);
      cyc(4'd5, 1'b1, 1'b0);
      cyc(4'd10, 1'b1, 1'b0);
      cyc(4'd3, 1'b1, 1'b0);
      check("t7_queued", 32'(evt_valid), 32'd1);
      rst = 1'b1;
      cyc(4'd3, 1'b1, 1'b0);
      rst = 1'b0;
      check("t7_rst_valid", 32'(evt_valid), 32'd0);
      check("t7_rst_data", 32'(evt_data), 32'd0);
      check("t7_rst_full", 32'(fifo_full), 32'd0);
      cyc(4'd5, 1'b1, 1'b0);
      check("t7_first_sample", 32'(evt_valid), 32'd0);
      cyc(4'd6, 1'b1, 1'b0);
      check("t7_normal", 32'(evt_valid), 32'd0);

`ifdef CNT_EVENT_SAMPLER_TIMESTAMP_EN
      // Timestamp of a WRAP classified on the 21st edge after reset
      do_reset();
      for (int k = 0; k < 16; k++) cyc(4'd0, 1'b0, 1'b0);
      for (int k = 12; k <= 15; k++) cyc(4'(k), 1'b1, 1'b0);
      cyc(4'd0, 1'b1, 1'b0);
      check("t8_ts", 32'(evt_data[25:10]), 32'd20);
      check("t8_rec", 32'(evt_data[9:0]), 32'h1F0);
`endif

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cnt_event_sampler.md
Name: cnt_event_sampler

Overview:
- Downstream consumer of the 4-bit free-running counter stage.
- Samples the counter value each qualified cycle and classifies each transition against the previous sample: normal increment, wrap, jump or restart.
- Pushes non-normal transitions as event records into a small show-ahead FIFO drained through a valid/ready port.
- Keeps saturating wrap and drop statistics for the simulation harness.

Parameters:
- DEPTH, 4, event FIFO entries; power of two, minimum 2.
- STAT_W, 8, width of the wrap_count and drop_count statistics counters.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset; synchronous, active-high, sampled on posedge clk.
- cnt_in  input  4  counter value from the upstream counter stage.
- cnt_valid  input  1  cnt_in is qualified this cycle; tie high for a free-running counter.
- evt_valid  output  1  FIFO head holds a record.
- evt_ready  input  1  consumer accepts the head record this cycle.
- evt_data  output  10  head record: [9:8] type, [7:4] prev, [3:0] cur.
- fifo_full  output  1  FIFO holds DEPTH records.
- overflow  output  1  sticky flag: at least one record has been dropped.
- wrap_count  output  STAT_W  number of WRAP events detected, saturating.
- drop_count  output  STAT_W  number of records dropped while the FIFO was full, saturating.

Behaviour:
- Reset: rst high at posedge gives:
  - state=INIT; FIFO emptied; evt_valid=0; evt_data=0; fifo_full=0; overflow=0; wrap_count=0; drop_count=0; prev register=0.
  - Reset mid-operation discards all queued records. The first qualified sample after reset is treated as a fresh INIT.
- States:
  - INIT: waiting for the first sample. On a posedge with cnt_valid=1: latch prev<=cnt_in, go to TRACK, no event.
  - TRACK: on each posedge with cnt_valid=1, compare cur=cnt_in against prev, then prev<=cnt_in.
  - cnt_valid=0: no compare, no prev update, state held.
- Classification in TRACK (4-bit arithmetic, modulo 16), in priority order:
  - cur==prev: stall, no event.
  - prev==15 and cur==0: WRAP, type 2'b01; wrap_count increments.
  - cur==0 and prev!=15: RESTART, type 2'b11.
  - cur==prev+1: normal, no event.
  - Anything else: JUMP, type 2'b10.
- Latency:
  - A record is written on the same posedge where the sample is classified.
  - evt_valid rises in the following cycle, one cycle after cnt_in was presented.
  - evt_data is the registered FIFO head, stable while evt_valid=1 and evt_ready=0.
- Handshake:
  - A pop occurs at a posedge with evt_valid=1 and evt_ready=1.
  - evt_ready while empty is ignored.
  - evt_valid never drops without a pop or a reset.
- FIFO:
  - Pointers are log2(DEPTH) bits wide, plus one extra bit for full/empty disambiguation.
  - Pointers wrap naturally.
  - fifo_full is registered and asserts the cycle after the count reaches DEPTH.
- Simultaneous push and pop:
  - Both happen in the same cycle; occupancy is unchanged.
  - This is allowed when the FIFO is full: the push is accepted, not dropped.
  - When the FIFO is empty, the pushed record appears at the head the next cycle.
- Overflow:
  - Push while full with no pop in the same cycle: the record is dropped.
  - drop_count increments and overflow is set to 1.
  - overflow is cleared only by reset.
- Saturation: wrap_count and drop_count stick at 2^STAT_W-1 and never wrap to 0.

Optional Feature:
- Macro: CNT_EVENT_SAMPLER_TIMESTAMP_EN.
- Defined:
  - Adds a 16-bit free-running cycle counter, reset to 0 and wrapping at 65535.
  - evt_data widens to 26 bits: [25:10] timestamp of the classifying posedge, [9:0] unchanged.
  - FIFO storage widens to match.
- Undefined: evt_data is 10 bits; no timestamp logic is built.

Test Plan:
- Reset, cnt_valid=1, cnt_in counting 1..15,0,1 with evt_ready=1 -> exactly one record {01,1111,0000}; evt_valid high exactly one cycle, one cycle after cnt_in=0; wrap_count=1.
- cnt_in sequence 3,4,9 -> record {10,0100,1001}; then 9,0 -> record {11,1001,0000}; wrap_count stays 0.
- cnt_in held at 7 for 5 cycles, and separately cnt_valid=0 during a jump 2->8 -> no records; the next valid sample is compared against the last valid sample only.
- evt_ready=0, DEPTH=4, 6 JUMP events -> fifo_full=1 after the 4th; drop_count=2; overflow=1. Then drain with evt_ready=1 -> the 4 oldest records emerge in order; overflow stays 1.
- FIFO full, a new event arrives and a pop occurs in the same cycle -> no drop; occupancy stays 4; the new record is last out.
- rst asserted with 3 records queued -> next cycle evt_valid=0, counters 0, state INIT. The first sample after reset (e.g. 5) creates no event. With CNT_EVENT_SAMPLER_TIMESTAMP_EN defined, a WRAP at cycle 20 after reset carries timestamp 20.
